// File: rtl/reg_operand_stage_if.sv
// Operand-stage bus: request side from decode, result side to the ALU,
// and the writeback path that loops ALU results back into the register file.
// The stage itself uses the slave modport; the driver of the stage uses master.
interface reg_operand_stage_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  id_valid;
   logic                  id_ready;
   logic [ADDR_WIDTH-1:0] AD1;
   logic [ADDR_WIDTH-1:0] AD2;
   logic [WIDTH-1:0]      ImmOp;
   logic                  ALUsrc;
   logic [2:0]            ALUctrl_in;
   logic                  flush;
   logic                  WE3;
   logic [ADDR_WIDTH-1:0] AD3;
   logic [WIDTH-1:0]      WD3;
   logic                  ex_valid;
   logic                  ex_ready;
   logic [WIDTH-1:0]      ALUop1;
   logic [WIDTH-1:0]      ALUop2;
   logic [2:0]            ALUctrl;
   logic [WIDTH-1:0]      a0;

   modport master (
      output id_valid, AD1, AD2, ImmOp, ALUsrc, ALUctrl_in, flush,
      output WE3, AD3, WD3, ex_ready,
      input  id_ready, ex_valid, ALUop1, ALUop2, ALUctrl, a0
   );

   modport slave (
      input  id_valid, AD1, AD2, ImmOp, ALUsrc, ALUctrl_in, flush,
      input  WE3, AD3, WD3, ex_ready,
      output id_ready, ex_valid, ALUop1, ALUop2, ALUctrl, a0
   );
endinterface

// File: rtl/reg_operand_stage.sv
// Register file plus a one-entry operand register feeding the ALU.
// Reads rs1/rs2 combinationally, picks immediate or rs2 for operand 2 and
// holds the operand pair behind a valid/ready handshake.
// Optional macro REGFILE_BYPASS_EN: when defined, a read of the register being
// written this cycle returns the write data instead of the old contents.
module reg_operand_stage #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic             clk,
   input logic             rst_n,
   reg_operand_stage_if.slave bus
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam int A0_IDX   = 10;

   logic [WIDTH-1:0] regs_q [NUM_REGS];
   logic [WIDTH-1:0] regs_d [NUM_REGS];

   logic             ex_valid_q, ex_valid_d;
   logic [WIDTH-1:0] alu_op1_q, alu_op1_d;
   logic [WIDTH-1:0] alu_op2_q, alu_op2_d;
   logic [2:0]       alu_ctrl_q, alu_ctrl_d;

   logic             wr_en;
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;
   logic [WIDTH-1:0] op2_sel;
   logic             id_ready;
   logic             accept;

   assign wr_en    = bus.WE3 && (bus.AD3 != '0);
   assign id_ready = !ex_valid_q || bus.ex_ready;
   assign accept   = bus.id_valid && id_ready && !bus.flush;
   assign op2_sel  = bus.ALUsrc ? bus.ImmOp : rd2;

   // Next register-file contents: a single write port, register 0 never written
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[bus.AD3] = bus.WD3;
      end
   end

   // Combinational read ports, register 0 hardwired to zero
   always_comb begin
      rd1 = '0;
      rd2 = '0;
`ifdef REGFILE_BYPASS_EN
      if (bus.AD1 != '0) begin
         rd1 = (wr_en && (bus.AD3 == bus.AD1)) ? bus.WD3 : regs_q[bus.AD1];
      end
      if (bus.AD2 != '0) begin
         rd2 = (wr_en && (bus.AD3 == bus.AD2)) ? bus.WD3 : regs_q[bus.AD2];
      end
`else
      if (bus.AD1 != '0) begin
         rd1 = regs_q[bus.AD1];
      end
      if (bus.AD2 != '0) begin
         rd2 = regs_q[bus.AD2];
      end
`endif
   end

   // Operand register: flush wins, then capture on accept, then drain on ready
   always_comb begin
      ex_valid_d = ex_valid_q;
      alu_op1_d  = alu_op1_q;
      alu_op2_d  = alu_op2_q;
      alu_ctrl_d = alu_ctrl_q;
      if (bus.flush) begin
         ex_valid_d = 1'b0;
      end else if (accept) begin
         ex_valid_d = 1'b1;
         alu_op1_d  = rd1;
         alu_op2_d  = op2_sel;
         alu_ctrl_d = bus.ALUctrl_in;
      end else if (bus.ex_ready) begin
         ex_valid_d = 1'b0;
      end
   end

   // Register file state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Operand pipeline register state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q <= 1'b0;
         alu_op1_q  <= '0;
         alu_op2_q  <= '0;
         alu_ctrl_q <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         alu_op1_q  <= alu_op1_d;
         alu_op2_q  <= alu_op2_d;
         alu_ctrl_q <= alu_ctrl_d;
      end
   end

   assign bus.id_ready = id_ready;
   assign bus.ex_valid = ex_valid_q;
   assign bus.ALUop1   = alu_op1_q;
   assign bus.ALUop2   = alu_op2_q;
   assign bus.ALUctrl  = alu_ctrl_q;
   assign bus.a0       = regs_q[A0_IDX];
endmodule

// File: tb/tb_reg_operand_stage.sv
// Self-checking bench for reg_operand_stage: a reference register file and a
// scoreboard queue of expected operand entries, pushed on accept and compared
// while the entry sits at the ALU side.
module tb_reg_operand_stage;
   localparam int WIDTH      = 32;
   localparam int ADDR_WIDTH = 5;

   typedef struct packed {
      logic [WIDTH-1:0] op1;
      logic [WIDTH-1:0] op2;
      logic [2:0]       ctrl;
   } entry_t;

   logic clk;
   logic rst_n;

   reg_operand_stage_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   reg_operand_stage #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   entry_t           sb[$];
   logic [WIDTH-1:0] model[32];
   int               assertCount = 0;
   int               failCount   = 0;

   // Free-running clock, 10 time-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against the bench's expectation
   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
      assertCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference read port including the optional same-cycle bypass
   function automatic logic [WIDTH-1:0] readModel(input logic [4:0] a, input logic we,
                                                  input logic [4:0] a3,
                                                  input logic [WIDTH-1:0] wd);
      if (a == 5'd0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (we && (a3 != 5'd0) && (a3 == a)) return wd;
`endif
      return model[a];
   endfunction

   // Drive one cycle of inputs at the falling edge, check, advance the model
   task automatic applyStimulus(input logic idv, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [WIDTH-1:0] imm, input logic src,
                                input logic [2:0] ctrl, input logic fl, input logic we,
                                input logic [4:0] a3, input logic [WIDTH-1:0] wd,
                                input logic exr);
      logic   rdy;
      entry_t e;
      bus.id_valid   = idv;
      bus.AD1        = a1;
      bus.AD2        = a2;
      bus.ImmOp      = imm;
      bus.ALUsrc     = src;
      bus.ALUctrl_in = ctrl;
      bus.flush      = fl;
      bus.WE3        = we;
      bus.AD3        = a3;
      bus.WD3        = wd;
      bus.ex_ready   = exr;
      #1;
      rdy = (sb.size() == 0) || exr;
      checkOutput("ex_valid", {31'd0, bus.ex_valid}, {31'd0, sb.size() != 0});
      checkOutput("id_ready", {31'd0, bus.id_ready}, {31'd0, rdy});
      checkOutput("a0", bus.a0, model[10]);
      if (sb.size() != 0) begin
         checkOutput("ALUop1", bus.ALUop1, sb[0].op1);
         checkOutput("ALUop2", bus.ALUop2, sb[0].op2);
         checkOutput("ALUctrl", {29'd0, bus.ALUctrl}, {29'd0, sb[0].ctrl});
         if (exr || fl) void'(sb.pop_front());
      end
      if (idv && rdy && !fl) begin
         e.op1  = readModel(a1, we, a3, wd);
         e.op2  = src ? imm : readModel(a2, we, a3, wd);
         e.ctrl = ctrl;
         sb.push_back(e);
      end
      if (we && (a3 != 5'd0)) model[a3] = wd;
      @(negedge clk);
   endtask

   // Test sequence
   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      rst_n = 1'b0;
      bus.id_valid = 0; bus.AD1 = 0; bus.AD2 = 0; bus.ImmOp = 0; bus.ALUsrc = 0;
      bus.ALUctrl_in = 0; bus.flush = 0; bus.WE3 = 0; bus.AD3 = 0; bus.WD3 = 0;
      bus.ex_ready = 0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("rst id_ready", {31'd0, bus.id_ready}, 32'd1);
      checkOutput("rst ALUop1", bus.ALUop1, 32'd0);
      checkOutput("rst ALUop2", bus.ALUop2, 32'd0);
      checkOutput("rst ALUctrl", {29'd0, bus.ALUctrl}, 32'd0);
      checkOutput("rst a0", bus.a0, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Read x10 and x0 straight after reset
      applyStimulus(1, 5'd10, 5'd0, 32'd0, 0, 3'd0, 0, 0, 5'd0, 32'd0, 1);
      applyStimulus(0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0, 0, 5'd0, 32'd0, 1);

      // Write x5 then read it with an immediate operand 2
      applyStimulus(0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0, 1, 5'd5, 32'h0000_00FF, 1);
      applyStimulus(1, 5'd5, 5'd0, 32'hFFFF_FFFC, 1, 3'b001, 0, 0, 5'd0, 32'd0, 1);
      applyStimulus(0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0, 0, 5'd0, 32'd0, 1);

      // Write to x0 is ignored even when read in the same cycle
      applyStimulus(1, 5'd0, 5'd0, 32'd0, 0, 3'd2, 0, 1, 5'd0, 32'h0000_1234, 1);
      applyStimulus(0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0, 0, 5'd0, 32'd0, 1);

      // Same-cycle write and read of x7, then confirm the write landed
      applyStimulus(1, 5'd0, 5'd7, 32'd0, 0, 3'd3, 0, 1, 5'd7, 32'hA5A5_A5A5, 1);
      applyStimulus(1, 5'd7, 5'd5, 32'd0, 0, 3'd4, 0, 0, 5'd0, 32'd0, 1);
      applyStimulus(0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0, 0, 5'd0, 32'd0, 1);

      // Backpressure: held entry is stable and ignores a writeback to its source
      applyStimulus(1, 5'd5, 5'd7, 32'd0, 0, 3'd2, 0, 0, 5'd0, 32'd0, 0);
      applyStimulus(1, 5'd7, 5'd7, 32'd0, 0, 3'd5, 0, 1, 5'd5, 32'h5555_0000, 0);
      applyStimulus(1, 5'd7, 5'd7, 32'd0, 0, 3'd5, 0, 0, 5'd0, 32'd0, 0);
      applyStimulus(1, 5'd7, 5'd7, 32'd0, 0, 3'd5, 0, 0, 5'd0, 32'd0, 0);
      applyStimulus(1, 5'd5, 5'd7, 32'd0, 0, 3'd6, 0, 0, 5'd0, 32'd0, 1);
      applyStimulus(0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0, 1, 5'd10, 32'h0000_CAFE, 1);

      // Flush a held entry while a new request is offered; writeback still commits
      applyStimulus(1, 5'd10, 5'd5, 32'd0, 0, 3'd7, 0, 0, 5'd0, 32'd0, 0);
      applyStimulus(1, 5'd5, 5'd5, 32'd0, 0, 3'd1, 1, 1, 5'd3, 32'h3333_3333, 0);
      applyStimulus(1, 5'd3, 5'd10, 32'd0, 0, 3'd1, 0, 0, 5'd0, 32'd0, 0);

      // Asynchronous reset pulse between edges with an entry held
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async ex_valid", {31'd0, bus.ex_valid}, 32'd0);
      checkOutput("async a0", bus.a0, 32'd0);
      checkOutput("async ALUop1", bus.ALUop1, 32'd0);
      #1;
      rst_n = 1'b1;
      sb.delete();
      for (int i = 0; i < 32; i++) model[i] = '0;
      @(negedge clk);
      applyStimulus(1, 5'd3, 5'd5, 32'd0, 0, 3'd2, 0, 0, 5'd0, 32'd0, 1);

      // Randomised traffic with back-to-back accepts, stalls and flushes
      for (int n = 0; n < 60; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                       5'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
                       1'($urandom_range(0, 3) != 0));
      end
      applyStimulus(0, 5'd0, 5'd0, 32'd0, 0, 3'd0, 0, 0, 5'd0, 32'd0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule

// File: doc/reg_operand_stage.md
Name: reg_operand_stage

Overview:
- Register file plus one-entry operand pipeline register, directly upstream of the ALU.
- Reads rs1/rs2, selects immediate vs. register for operand 2, and registers ALUop1/ALUop2/ALUctrl toward the ALU.
- Uses a valid/ready handshake on both sides.
- Accepts writeback from the result path, so the ALU result loops back through this block.

Parameters:
- WIDTH, 32, data width of registers and operands.
- ADDR_WIDTH, 5, register address width; register count is 2**ADDR_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  upstream has an instruction's operand request.
- id_ready  output  1  stage can accept a request this cycle.
- AD1  input  ADDR_WIDTH  source register 1 address.
- AD2  input  ADDR_WIDTH  source register 2 address.
- ImmOp  input  WIDTH  sign-extended immediate.
- ALUsrc  input  1  1 selects ImmOp for operand 2, 0 selects register AD2.
- ALUctrl_in  input  3  ALU operation code, passed through.
- flush  input  1  discard the held and incoming entries.
- WE3  input  1  writeback enable.
- AD3  input  ADDR_WIDTH  writeback address.
- WD3  input  WIDTH  writeback data.
- ex_valid  output  1  registered operands valid toward the ALU.
- ex_ready  input  1  ALU side consumes the entry this cycle.
- ALUop1  output  WIDTH  registered operand 1.
- ALUop2  output  WIDTH  registered operand 2.
- ALUctrl  output  3  registered operation code.
- a0  output  WIDTH  live contents of register 10, for debug and test.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers are set to 0.
  - ex_valid=0; ALUop1=0, ALUop2=0, ALUctrl=0.
  - id_ready reads 1 once ex_valid is 0.
- Register file:
  - Write on the rising edge when WE3=1 and AD3!=0.
  - Register 0 always reads 0; writes to it are ignored.
  - Reads are combinational from AD1/AD2.
- Operand select: op2 = ALUsrc ? ImmOp : RD2; op1 = RD1. No width change.
- Handshake rules:
  - id_ready = !ex_valid || ex_ready (combinational, no skid buffer).
  - Accept when id_valid && id_ready && !flush. On accept, capture op1, op2 and ALUctrl_in; ex_valid<=1 next edge.
  - Else if ex_ready=1, ex_valid<=0.
  - Else hold all outputs stable.
- Latency: 1 cycle from accept to ex_valid.
- Throughput: 1 entry per cycle when ex_ready is held high.
- flush=1:
  - ex_valid<=0 at the next edge, regardless of id_valid or ex_ready.
  - The incoming request is dropped; data registers may keep stale values.
  - Writeback in the same cycle still commits.
- Held-entry hazard: while ex_valid=1 and ex_ready=0, a writeback to a source register does NOT update the held operands. Upstream owns that hazard.
- Same-edge write and read: the result depends on REGFILE_BYPASS_EN (see Optional Feature).
- Reset asserted mid-operation: clears the register file and drops the held entry immediately, without waiting for a clock edge.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: if WE3=1, AD3!=0 and AD3 equals AD1 (or AD2), that read returns WD3 in the same cycle, so a same-cycle accept captures the new value.
- Undefined: reads return the pre-edge register contents; the written value is visible from the following cycle.
- In both cases register 0 reads 0.

Test Plan:
- Reset, then AD1=10, AD2=0, ALUsrc=0, accept -> ALUop1=0, ALUop2=0, a0=0, ex_valid=1 one cycle after accept.
- Write WE3=1, AD3=5, WD3=0x0000_00FF. Next cycle accept AD1=5, ALUsrc=1, ImmOp=0xFFFF_FFFC, ALUctrl_in=3'b001 -> ALUop1=0xFF, ALUop2=0xFFFF_FFFC, ALUctrl=3'b001.
- Write AD3=0, WD3=0x1234 and simultaneously accept AD1=0 -> ALUop1=0 with the macro defined or undefined.
- Same-cycle write AD3=7, WD3=0xA5A5_A5A5 with accept AD2=7, ALUsrc=0 -> ALUop2=0xA5A5_A5A5 with REGFILE_BYPASS_EN; old value 0 without it.
- Hold ex_ready=0 for 3 cycles after accept while id_valid=1 -> id_ready=0, outputs unchanged. Then ex_ready=1 -> next entry appears the following cycle.
- flush=1 while ex_valid=1 and id_valid=1 -> ex_valid=0 next cycle, no capture. Separately, pulse rst_n low between edges -> ex_valid=0 immediately and a0 reads 0.
